// File: rtl/unidade_controle_multijogador_pkg.sv
// rtl/unidade_controle_multijogador_pkg.sv - state codes and saturating helpers shared by the game controller
package unidade_controle_multijogador_pkg;

  // State codes are the debug codes shown on db_estado
  typedef enum logic [3:0] {
    inicial         = 4'h0,
    iniciaElementos = 4'h1,
    espera          = 4'h2,
    registra        = 4'h3,
    compara         = 4'h4,
    geraJogada      = 4'h6,
    fimJogada       = 4'h9,
    contaPonto      = 4'hA,
    decresce        = 4'hE,
    fim             = 4'hF
  } estadoT;

  function automatic logic [31:0] satSub(input logic [31:0] valor, input logic [31:0] desconto);
    return (valor > desconto) ? (valor - desconto) : 32'd0;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] valor, input logic [31:0] incremento,
                                         input logic [31:0] maximo);
    return ((valor + incremento) > maximo) ? maximo : (valor + incremento);
  endfunction

endpackage

// File: rtl/unidade_controle_multijogador_relogio_jogador.sv
// rtl/unidade_controle_multijogador_relogio_jogador.sv - one player's saturating countdown clock
module unidade_controle_multijogador_relogio_jogador
  import unidade_controle_multijogador_pkg::*;
#(
  parameter int TEMPO_INI = 300,
  parameter int TEMPO_W   = 9,
  parameter int PENALTY   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carga,
  input  logic               contar,
  input  logic               penalizar,
  output logic [TEMPO_W-1:0] tempo,
  output logic               zero
);

  logic [31:0] desconto;

  // Tick and penalty landing in the same cycle are removed together
  always_comb begin
    desconto = (contar ? 32'd1 : 32'd0) + (penalizar ? 32'(PENALTY) : 32'd0);
  end

  // Load on game start, otherwise count down and stick at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tempo <= TEMPO_W'(TEMPO_INI);
    end else if (carga) begin
      tempo <= TEMPO_W'(TEMPO_INI);
    end else begin
      tempo <= TEMPO_W'(satSub(32'(tempo), desconto));
    end
  end

  assign zero = (tempo == '0);

endmodule

// File: rtl/unidade_controle_multijogador.sv
// rtl/unidade_controle_multijogador.sv - N-player turn controller with clocks and scores; STREAK_BONUS_EN adds streak bonus
module unidade_controle_multijogador
  import unidade_controle_multijogador_pkg::*;
#(
  parameter int N_JOG     = 2,
  parameter int JOG_W     = 1,
  parameter int TEMPO_INI = 300,
  parameter int TEMPO_W   = 9,
  parameter int PENALTY   = 10,
  parameter int SCORE_W   = 6,
`ifdef STREAK_BONUS_EN
  parameter int STREAK_N  = 3,
`endif
  parameter int ALVO      = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     tick,
  input  logic                     temJogada,
  input  logic                     acertou,
  input  logic                     terminar,
  output logic                     registraR,
  output logic                     zeraR,
  output logic                     geraNova,
  output logic [JOG_W-1:0]         jogador,
  output logic [TEMPO_W-1:0]       tempo,
  output logic [N_JOG*SCORE_W-1:0] pontos,
  output logic                     fimT,
  output logic [JOG_W-1:0]         vencedor,
  output logic [3:0]               db_estado
);

  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  estadoT             estado;
  logic [SCORE_W-1:0] placar [N_JOG];
  logic [TEMPO_W-1:0] relogio [N_JOG];
  logic [N_JOG-1:0]   zerado;
  logic               contagemAtiva;
  logic               alvoAtingido;
  logic [JOG_W-1:0]   melhor;
  logic [SCORE_W-1:0] melhorPontos;
  logic               achou;
  logic               algumVivo;

`ifdef STREAK_BONUS_EN
  localparam int STREAK_W = $clog2(STREAK_N + 1);
  logic [STREAK_W-1:0] sequencia [N_JOG];
`endif

  // Clocks run only while a turn is in progress
  always_comb begin
    contagemAtiva = estado inside {espera, registra, compara, decresce, contaPonto, geraJogada};
  end

  for (genvar k = 0; k < N_JOG; k++) begin : gJogador
    unidade_controle_multijogador_relogio_jogador #(
      .TEMPO_INI(TEMPO_INI),
      .TEMPO_W  (TEMPO_W),
      .PENALTY  (PENALTY)
    ) uRelogio (
      .clock    (clock),
      .reset    (reset),
      .carga    (estado == iniciaElementos),
      .contar   (tick && contagemAtiva && (jogador == JOG_W'(k))),
      .penalizar((estado == decresce) && (jogador == JOG_W'(k))),
      .tempo    (relogio[k]),
      .zero     (zerado[k])
    );
    assign pontos[k*SCORE_W +: SCORE_W] = placar[k];
  end

  assign tempo     = relogio[jogador];
  assign db_estado = estado;

  // Winner: best score among players with time left (everyone if all are out), ties to lowest index
  always_comb begin
    algumVivo    = ~&zerado;
    melhor       = '0;
    melhorPontos = '0;
    achou        = 1'b0;
    for (int k = 0; k < N_JOG; k++) begin
      if ((!algumVivo || !zerado[k]) && (!achou || (placar[k] > melhorPontos))) begin
        melhor       = JOG_W'(k);
        melhorPontos = placar[k];
        achou        = 1'b1;
      end
    end
  end

  // Target score reached by any player (ALVO of zero disables it)
  always_comb begin
    alvoAtingido = 1'b0;
    for (int k = 0; k < N_JOG; k++) begin
      if ((ALVO != 0) && (32'(placar[k]) >= 32'(ALVO))) alvoAtingido = 1'b1;
    end
  end

  // Game FSM with registered Moore outputs, scores, streaks and turn order
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= inicial;
      jogador   <= '0;
      vencedor  <= '0;
      registraR <= 1'b0;
      zeraR     <= 1'b0;
      geraNova  <= 1'b0;
      fimT      <= 1'b0;
      for (int k = 0; k < N_JOG; k++) placar[k] <= '0;
`ifdef STREAK_BONUS_EN
      for (int k = 0; k < N_JOG; k++) sequencia[k] <= '0;
`endif
    end else begin
      registraR <= 1'b0;
      zeraR     <= 1'b0;
      geraNova  <= 1'b0;
      fimT      <= 1'b0;
      case (estado)
        inicial: begin
          if (iniciar) begin
            estado   <= iniciaElementos;
            geraNova <= 1'b1;
          end
        end
        iniciaElementos: begin
          for (int k = 0; k < N_JOG; k++) placar[k] <= '0;
`ifdef STREAK_BONUS_EN
          for (int k = 0; k < N_JOG; k++) sequencia[k] <= '0;
`endif
          jogador <= '0;
          estado  <= espera;
        end
        espera: begin
          if (zerado[jogador]) begin
            estado   <= fim;
            fimT     <= 1'b1;
            vencedor <= melhor;
          end else if (temJogada) begin
            estado    <= registra;
            registraR <= 1'b1;
          end
        end
        registra: estado <= compara;
        compara:  estado <= acertou ? contaPonto : decresce;
        decresce: begin
`ifdef STREAK_BONUS_EN
          sequencia[jogador] <= '0;
`endif
          estado <= fimJogada;
          zeraR  <= 1'b1;
        end
        contaPonto: begin
`ifdef STREAK_BONUS_EN
          if (sequencia[jogador] == STREAK_W'(STREAK_N - 1)) begin
            placar[jogador]    <= SCORE_W'(satInc(32'(placar[jogador]), 32'd2, 32'(SCORE_MAX)));
            sequencia[jogador] <= '0;
          end else begin
            placar[jogador]    <= SCORE_W'(satInc(32'(placar[jogador]), 32'd1, 32'(SCORE_MAX)));
            sequencia[jogador] <= sequencia[jogador] + STREAK_W'(1);
          end
`else
          placar[jogador] <= SCORE_W'(satInc(32'(placar[jogador]), 32'd1, 32'(SCORE_MAX)));
`endif
          estado   <= geraJogada;
          geraNova <= 1'b1;
        end
        geraJogada: begin
          estado <= fimJogada;
          zeraR  <= 1'b1;
        end
        fimJogada: begin
          jogador <= (jogador == JOG_W'(N_JOG - 1)) ? '0 : jogador + JOG_W'(1);
          if (alvoAtingido) begin
            estado   <= fim;
            fimT     <= 1'b1;
            vencedor <= melhor;
          end else begin
            estado <= espera;
          end
        end
        fim: begin
          if (terminar) estado <= inicial;
          else          fimT   <= 1'b1;
        end
        default: estado <= inicial;
      endcase
    end
  end

endmodule
